interp_stepper: RTL and testbench
=================================

Name: interp_stepper

Overview:
- Consumer end of the slope path in the rgb-lab pipeline. Takes a segment base value and the fixed-point slope produced upstream (DT_I.DT_D format, one per X_DISPLACEMENT-wide segment).
- Regenerates the X_DISPLACEMENT interpolated samples base + k*delta (k = 0..X_DISPLACEMENT-1) as a valid/ready stream for the LUT-interpolation stage.
- Accepts one segment request at a time and supports back-to-back segments with no bubble.

Parameters:
- X_DISPLACEMENT, 16: samples per segment; must be at least 2.
- DSIZE, 16: width of the base value and of the output samples.
- DT_I, 8: integer bits of delta.
- DT_D, 4: fractional bits of delta.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg_valid  input  1  segment request valid.
- seg_ready  output  1  segment request accepted when high together with seg_valid.
- y_base  input  DSIZE  segment start value (integer).
- delta  input  DT_I+DT_D  unsigned slope, DT_I.DT_D fixed point.
- out_valid  output  1  sample valid.
- out_ready  input  1  downstream accepts sample.
- out_data  output  DSIZE  interpolated sample (integer part, truncated).
- out_last  output  1  high with the final sample of a segment (k = X_DISPLACEMENT-1).
- out_sat  output  1  high when out_data is clamped.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; out_valid = 0; out_last = 0; out_sat = 0; out_data = 0.
  - Accumulator, counter and delta register cleared.
  - seg_ready = 1 after reset release.
- Registers:
  - acc is DSIZE+DT_D bits (DSIZE.DT_D).
  - cnt is $clog2(X_DISPLACEMENT) bits.
  - dreg holds the captured delta.
  - sat is a sticky flag.
- States: IDLE and RUN.
- IDLE:
  - seg_ready = 1, out_valid = 0.
  - On seg_valid: acc <= {y_base, DT_D'b0}, dreg <= delta, cnt <= 0, sat <= 0, go to RUN.
- RUN:
  - out_valid = 1.
  - out_data = sat ? all-ones : acc[DT_D +: DSIZE].
  - out_sat = sat.
  - out_last = (cnt == X_DISPLACEMENT-1).
- Beat handshake: out_valid && out_ready.
  - Not last beat: cnt <= cnt+1. acc <= acc + dreg, computed at DSIZE+DT_D+1 bits. If the carry-out is set, or sat is already set: acc <= all-ones and sat <= 1.
  - Last beat with seg_valid high: the new segment loads as in IDLE and the state stays RUN. The first sample of the new segment appears the very next cycle (no bubble).
  - Last beat with seg_valid low: go to IDLE.
- seg_ready = (state == IDLE) || (state == RUN && out_last && out_ready). This is combinational, from state and out_ready only; seg_valid does not feed it.
- Backpressure: while out_valid && !out_ready, out_data, out_last, out_sat, acc and cnt all hold.
- Latency: request accepted at edge N means first sample valid in the cycle after edge N. There is one sample per accepted beat thereafter.
- Delta:
  - All-ones delta (upstream saturation code) is treated as an ordinary numeric value; clamping then happens via sat.
  - delta = 0 yields X_DISPLACEMENT copies of y_base.
- Once sat is set in a segment, all remaining samples of that segment are all-ones with out_sat = 1. sat clears when the next segment loads.
- Inputs y_base and delta are sampled only on the accepting edge; later changes are ignored.
- Reset asserted mid-segment: the segment is aborted immediately, out_valid drops asynchronously, and there is no partial resumption after release.

Test Plan:
- y_base=100, delta=0x010 (1.0), out_ready=1 -> out_data 100,101,...,115 on consecutive cycles; out_last only on 115; out_sat=0; back to IDLE, seg_ready=1.
- y_base=100, delta=0x008 (0.5) -> 100,100,101,101,...,107,107; delta=0x000 -> sixteen samples of 100.
- y_base=0xFFF0, delta=0x020 (2.0) -> 0xFFF0,0xFFF2,...,0xFFFE (k=0..7), then 0xFFFF with out_sat=1 for k=8..15; next segment y_base=5, delta=0x010 -> out_sat=0, starts at 5.
- Backpressure: out_ready low for 3 cycles while sample k=5 (105) is presented -> out_data holds 105, cnt does not advance; sequence resumes at 106; still exactly 16 beats.
- Back-to-back: second request (y_base=200, delta=0x010) held valid during first segment -> seg_ready high only in the last-beat cycle; sample 200 follows 115 in the next cycle with no gap.
- Reset mid-run: rst_n low during k=7 -> out_valid=0 immediately, out_data=0; after release seg_ready=1 and a new request produces a full 16-sample sequence from k=0.

Source files
------------

// File: rtl/interp_stepper.sv
// Regenerates X_DISPLACEMENT interpolated samples base + k*delta per accepted segment as a valid/ready stream.
// Latency: first sample valid the cycle after acceptance; one sample per beat, back-to-back segments with no bubble.
// Backpressure: out_ready low holds every output and the accumulator; seg_ready rises only in IDLE or on the accepted last beat.
module interp_stepper #(
    parameter int X_DISPLACEMENT = 16,
    parameter int DSIZE          = 16,
    parameter int DT_I           = 8,
    parameter int DT_D           = 4
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic                   seg_valid,
    output logic                   seg_ready,
    input  logic [DSIZE-1:0]       y_base,
    input  logic [DT_I+DT_D-1:0]   delta,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DSIZE-1:0]       out_data,
    output logic                   out_last,
    output logic                   out_sat
);

    localparam int AW = DSIZE + DT_D;
    localparam int DW = DT_I + DT_D;
    localparam int CW = (X_DISPLACEMENT > 1) ? $clog2(X_DISPLACEMENT) : 1;
    localparam logic [CW-1:0] LAST_K = CW'(X_DISPLACEMENT - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_acc;
    logic [DW-1:0]   r_dreg;
    logic [CW-1:0]   r_cnt;
    logic            r_sat;

    logic            w_run;
    logic            w_last;
    logic            w_beat;
    logic            w_load;
    logic [AW:0]     w_sum;

    assign w_run  = (r_state == ST_RUN);
    assign w_last = w_run && (r_cnt == LAST_K);
    assign w_beat = w_run && out_ready;

    // Accepting a segment on the last beat keeps the pipeline full; seg_valid never feeds seg_ready.
    assign seg_ready = !w_run || (w_last && out_ready);
    assign w_load    = seg_valid && seg_ready;

    // One extra bit so the carry-out flags overflow of the DSIZE.DT_D accumulator.
    assign w_sum = {1'b0, r_acc} + {{(AW + 1 - DW){1'b0}}, r_dreg};

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_dreg  <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
        end else if (w_load) begin
            r_state <= ST_RUN;
            r_acc   <= {y_base, {DT_D{1'b0}}};
            r_dreg  <= delta;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
        end else if (w_beat) begin
            if (w_last) begin
                r_state <= ST_IDLE;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                if (w_sum[AW] || r_sat) begin
                    r_acc <= '1;
                    r_sat <= 1'b1;
                end else begin
                    r_acc <= w_sum[AW-1:0];
                end
            end
        end
    end

    assign out_valid = w_run;
    assign out_last  = w_last;
    assign out_sat   = w_run && r_sat;

    always_comb begin
        out_data = '0;
        if (w_run) begin
            out_data = r_sat ? {DSIZE{1'b1}} : r_acc[DT_D +: DSIZE];
        end
    end

endmodule

// File: tb/tb_interp_stepper.sv
// Directed bench for interp_stepper: ramp, fractional slope, saturation, backpressure, back-to-back and mid-run reset.
module tb_interp_stepper;

    logic        clock;
    logic        rst_n;
    logic        seg_valid;
    logic        seg_ready;
    logic [15:0] y_base;
    logic [11:0] delta;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_sat;

    int checks = 0;
    int errors = 0;

    interp_stepper #(
        .X_DISPLACEMENT(16),
        .DSIZE(16),
        .DT_I(8),
        .DT_D(4)
    ) dut (
        .clock(clock),
        .rst_n(rst_n),
        .seg_valid(seg_valid),
        .seg_ready(seg_ready),
        .y_base(y_base),
        .delta(delta),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .out_sat(out_sat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stimulus only: present a request for one edge, then scramble the inputs.
    task automatic send_req(input logic [15:0] b, input logic [11:0] d);
        seg_valid = 1'b1;
        y_base    = b;
        delta     = d;
        @(posedge clock);
        #1;
        seg_valid = 1'b0;
        y_base    = 16'hDEAD;
        delta     = 12'hABC;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'd0 || out_last !== 1'b0 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h last=%b sat=%b, required 0/0000/0/0",
                     out_valid, out_data, out_last, out_sat);
        end
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (seg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_seg_ready: got %b, required 1", seg_ready);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_ramp;
        send_req(16'd100, 12'h010);
        for (int k = 0; k < 16; k++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'(100 + k) || out_last !== (k == 15) ||
                out_sat !== 1'b0) begin
                errors++;
                $display("FAIL ramp k=%0d: valid=%b data=%0d last=%b sat=%b, required 1/%0d/%b/0",
                         k, out_valid, out_data, out_last, out_sat, 100 + k, (k == 15));
            end
            @(posedge clock);
            #1;
        end
        #1;
        checks++;
        if (out_valid !== 1'b0 || seg_ready !== 1'b1) begin
            errors++;
            $display("FAIL ramp_idle: valid=%b seg_ready=%b, required 0/1", out_valid, seg_ready);
        end
    endtask

    task automatic test_fractional;
        send_req(16'd100, 12'h008);
        for (int k = 0; k < 16; k++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'(100 + k / 2) || out_last !== (k == 15)) begin
                errors++;
                $display("FAIL half_slope k=%0d: valid=%b data=%0d last=%b, required 1/%0d/%b",
                         k, out_valid, out_data, out_last, 100 + k / 2, (k == 15));
            end
            @(posedge clock);
            #1;
        end
        send_req(16'd100, 12'h000);
        for (int k = 0; k < 16; k++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'd100 || out_last !== (k == 15)) begin
                errors++;
                $display("FAIL zero_slope k=%0d: valid=%b data=%0d last=%b, required 1/100/%b",
                         k, out_valid, out_data, out_last, (k == 15));
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_saturation;
        logic [15:0] exp_d;
        logic        exp_s;
        send_req(16'hFFF0, 12'h020);
        for (int k = 0; k < 16; k++) begin
            exp_d = (k < 8) ? 16'(16'hFFF0 + 2 * k) : 16'hFFFF;
            exp_s = (k >= 8);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d || out_sat !== exp_s) begin
                errors++;
                $display("FAIL saturate k=%0d: valid=%b data=%h sat=%b, required 1/%h/%b",
                         k, out_valid, out_data, out_sat, exp_d, exp_s);
            end
            @(posedge clock);
            #1;
        end
        send_req(16'd5, 12'h010);
        for (int k = 0; k < 16; k++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'(5 + k) || out_sat !== 1'b0) begin
                errors++;
                $display("FAIL sat_clear k=%0d: valid=%b data=%0d sat=%b, required 1/%0d/0",
                         k, out_valid, out_data, out_sat, 5 + k);
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_backpressure;
        int exp_k;
        send_req(16'd100, 12'h010);
        for (int c = 0; c < 19; c++) begin
            out_ready = !(c >= 5 && c < 8);
            exp_k     = (c < 5) ? c : ((c < 8) ? 5 : c - 3);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'(100 + exp_k) || out_last !== (exp_k == 15) ||
                (!out_ready && seg_ready !== 1'b0)) begin
                errors++;
                $display("FAIL backpressure c=%0d: valid=%b data=%0d last=%b seg_ready=%b, required 1/%0d/%b",
                         c, out_valid, out_data, out_last, seg_ready, 100 + exp_k, (exp_k == 15));
            end
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_beats: valid=%b after 16 beats, required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        seg_valid = 1'b1;
        y_base    = 16'd100;
        delta     = 12'h010;
        @(posedge clock);
        #1;
        y_base = 16'd200;
        for (int c = 0; c < 32; c++) begin
            if (c == 16) seg_valid = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'(100 + (c / 16) * 100 + (c % 16)) ||
                out_last !== ((c % 16) == 15) || (c < 16 && seg_ready !== (c == 15))) begin
                errors++;
                $display("FAIL back_to_back c=%0d: valid=%b data=%0d last=%b seg_ready=%b, required 1/%0d/%b",
                         c, out_valid, out_data, out_last, seg_ready,
                         100 + (c / 16) * 100 + (c % 16), ((c % 16) == 15));
            end
            @(posedge clock);
            #1;
        end
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_end: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_run;
        send_req(16'd100, 12'h010);
        for (int k = 0; k < 7; k++) begin
            @(posedge clock);
            #1;
        end
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd107) begin
            errors++;
            $display("FAIL mid_run_k7: valid=%b data=%0d, required 1/107", out_valid, out_data);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'd0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL async_abort: valid=%b data=%0d last=%b, required 0/0/0",
                     out_valid, out_data, out_last);
        end
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (seg_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: seg_ready=%b valid=%b, required 1/0", seg_ready, out_valid);
        end
        @(posedge clock);
        #1;
        send_req(16'd50, 12'h010);
        for (int k = 0; k < 16; k++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'(50 + k) || out_last !== (k == 15)) begin
                errors++;
                $display("FAIL restart k=%0d: valid=%b data=%0d last=%b, required 1/%0d/%b",
                         k, out_valid, out_data, out_last, 50 + k, (k == 15));
            end
            @(posedge clock);
            #1;
        end
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart_end: valid=%b, required 0", out_valid);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        seg_valid = 1'b0;
        out_ready = 1'b1;
        y_base    = '0;
        delta     = '0;
        test_reset();
        test_ramp();
        test_fractional();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
